atmega_spi_arbiter: RTL

//  Shares one atmega SPI master peripheral between REQ_CNT requesters. Drives the peripheral's

---
 rtl/atmega_spi_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/atmega_spi_arbiter.sv
// Round-robin sharing of one atmega SPI master (SPCR/SPSR/SPDR register bus) between REQ_CNT
// requesters. Define ATMEGA_SPI_ARB_TIMEOUT_EN to enable the SPIF poll watchdog and err_o.
module atmega_spi_arbiter #(
  parameter int                           REQ_CNT           = 4,
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 'h22,
  parameter int                           CS_SETUP_CYC      = 2,
  parameter int                           CS_HOLD_CYC       = 2,
  parameter int                           TIMEOUT_CYC       = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [REQ_CNT-1:0]           req_i,
  output logic [REQ_CNT-1:0]           gnt_o,
  input  logic [8*REQ_CNT-1:0]         cfg_i,
  input  logic [8*REQ_CNT-1:0]         tx_data_i,
  input  logic [REQ_CNT-1:0]           tx_valid_i,
  input  logic [REQ_CNT-1:0]           tx_last_i,
  output logic [REQ_CNT-1:0]           tx_ready_o,
  output logic [7:0]                   rx_data_o,
  output logic [REQ_CNT-1:0]           rx_valid_o,
  output logic [REQ_CNT-1:0]           cs_n_o,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr_o,
  output logic                         spi_wr_o,
  output logic                         spi_rd_o,
  output logic [7:0]                   spi_dat_o,
  input  logic [7:0]                   spi_dat_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int OW    = $clog2(REQ_CNT);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + CS_SETUP_CYC + CS_HOLD_CYC + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArb   = 3'd1;
  localparam logic [2:0] StCfg   = 3'd2;
  localparam logic [2:0] StSetup = 3'd3;
  localparam logic [2:0] StLoad  = 3'd4;
  localparam logic [2:0] StPoll  = 3'd5;
  localparam logic [2:0] StFetch = 3'd6;
  localparam logic [2:0] StHold  = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [REQ_CNT-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  // rr_q is the index where the next search starts (owner + 1 after each transaction).
  logic [OW-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic [REQ_CNT-1:0] rx_valid_q, rx_valid_d;

  logic [OW-1:0] arb_idx, pick;
  logic          pick_vld;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    arb_idx  = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      arb_idx = OW'((int'(rr_q) + i) % REQ_CNT);
      if (!pick_vld && req_i[arb_idx]) begin
        pick_vld = 1'b1;
        pick     = arb_idx;
      end
    end
  end

`ifdef ATMEGA_SPI_ARB_TIMEOUT_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = '0;
    last_d     = last_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = '0;
`ifdef ATMEGA_SPI_ARB_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: if (|req_i) state_d = StArb;
      StArb: begin
        if (pick_vld) begin
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          owner_d      = pick;
          state_d      = StCfg;
        end else begin
          state_d = StIdle;
        end
      end
      StCfg: state_d = StSetup;
      StSetup: begin
        if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) state_d = StLoad;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      StLoad: begin
        if (tx_valid_i[owner_q]) begin
          last_d  = tx_last_i[owner_q];
          state_d = StPoll;
        end else if (!req_i[owner_q]) begin
          state_d = StHold;
        end
      end
      StPoll: begin
        if (spi_dat_i[7]) state_d = StFetch;
`ifdef ATMEGA_SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StHold;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      StFetch: begin
        rx_data_d  = spi_dat_i;
        rx_valid_d = gnt_q;
        state_d    = last_q ? StHold : StLoad;
      end
      StHold: begin
        if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = (owner_q == OW'(REQ_CNT - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef ATMEGA_SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Register bus is decoded straight from state so a reset drops every strobe immediately.
  always_comb begin
    spi_wr_o   = 1'b0;
    spi_rd_o   = 1'b0;
    spi_addr_o = '0;
    spi_dat_o  = '0;
    case (state_q)
      StCfg: begin
        spi_wr_o   = 1'b1;
        spi_addr_o = SPCR_ADDR;
        spi_dat_o  = (cfg_i[8*owner_q +: 8] & 8'h7F) | 8'h50;
      end
      StLoad: begin
        if (tx_valid_i[owner_q]) begin
          spi_wr_o   = 1'b1;
          spi_addr_o = SPDR_ADDR;
          spi_dat_o  = tx_data_i[8*owner_q +: 8];
        end
      end
      StPoll: begin
        spi_rd_o   = 1'b1;
        spi_addr_o = SPSR_ADDR;
      end
      StFetch: begin
        spi_rd_o   = 1'b1;
        spi_addr_o = SPDR_ADDR;
      end
      default: ;
    endcase
  end

  assign gnt_o      = gnt_q;
  assign cs_n_o     = ~gnt_q;
  assign tx_ready_o = (state_q == StLoad) ? gnt_q : '0;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q != StIdle);

endmodule
